// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// in-order pipeline writeback and a long-latency unit (mul/div/load-miss).
// Long-latency results wait in a DEPTH-entry FIFO. A starvation counter
// forces a one-cycle pipeline stall so that a buffered head always drains.
// chk_hit reports pending buffered writes so that hazard logic can use them.
//
// Optional feature: define RF_WRITE_ARB_BYPASS_EN to let a long-latency
// result skip the FIFO when the arbiter is otherwise idle.
//
// Handshake semantics: on the mu side, a transfer happens at a rising edge
// where mu_valid && mu_ready. mu_ready does not depend on mu_valid. On the
// pipeline side, a request is taken in any cycle where pipe_wb_valid &&
// !pipe_stall. While pipe_stall is high, the pipeline holds its request
// stable.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_wb_valid,
    input  logic [4:0]      pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    output logic            pipe_stall,
    input  logic            mu_valid,
    input  logic [4:0]      mu_rd,
    input  logic [XLEN-1:0] mu_data,
    output logic            mu_ready,
    input  logic [4:0]      chk_rd,
    output logic            chk_hit,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_din
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;

    logic            fifo_empty;
    logic            bypass;
    logic            enq;
    logic            head_grant;
    logic            pipe_grant;
    logic            head_lost;
    logic            grant_any;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [DEPTH-1:0] entry_valid;

    assign fifo_empty = (count == '0);
    // Ready is taken from the count before any same-cycle dequeue.
    assign mu_ready   = (count != FULL_COUNT);

`ifdef RF_WRITE_ARB_BYPASS_EN
    assign bypass = fifo_empty && !pipe_stall && !pipe_wb_valid && mu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign enq        = mu_valid && mu_ready && !bypass;
    // A forced stall always grants the head. Otherwise the pipeline wins.
    assign head_grant = pipe_stall || (!pipe_wb_valid && !fifo_empty);
    assign pipe_grant = !pipe_stall && pipe_wb_valid;
    assign head_lost  = !fifo_empty && !head_grant;
    assign grant_any  = head_grant || pipe_grant || bypass;

    // Select the rd and data of the granted requester.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (head_grant) begin
            sel_rd   = mem_rd[rd_ptr];
            sel_data = mem_data[rd_ptr];
        end else if (pipe_grant) begin
            sel_rd   = pipe_wb_rd;
            sel_data = pipe_wb_data;
        end else if (bypass) begin
            sel_rd   = mu_rd;
            sel_data = mu_data;
        end
    end

    // Mark the physical slots that hold live entries, and match them against chk_rd.
    always_comb begin
        logic [PW-1:0] off;
        off         = '0;
        entry_valid = '0;
        chk_hit     = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            off            = PW'(j) - rd_ptr;
            entry_valid[j] = ({1'b0, off} < count);
            if (entry_valid[j] && (mem_rd[j] == chk_rd) && (chk_rd != 5'd0))
                chk_hit = 1'b1;
        end
    end

    // FIFO storage is written at the tail. The contents need no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_rd[wr_ptr]   <= mu_rd;
            mem_data[wr_ptr] <= mu_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq)        wr_ptr <= wr_ptr + 1'b1;
            if (head_grant) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, head_grant})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counter. The stall is raised for one cycle after STARVE_LIMIT lost cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else if (head_lost && (starve_cnt == STARVE_LAST)) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b1;
        end else begin
            starve_cnt <= head_lost ? starve_cnt + 1'b1 : '0;
            pipe_stall <= 1'b0;
        end
    end

    // Register-file write port. A write to x0 is consumed but never enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we  <= 1'b0;
            rf_rd  <= '0;
            rf_din <= '0;
        end else if (grant_any) begin
            rf_we  <= (sel_rd != 5'd0);
            rf_rd  <= sel_rd;
            rf_din <= sel_data;
        end else begin
            rf_we  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed bench for rf_write_arbiter with default
// parameters (DEPTH=4, STARVE_LIMIT=8, XLEN=32). Expected register-file
// writes are queued as stimulus is issued. A negedge monitor pops the queue
// and compares it on every rf_we pulse. Point checks cover the stall, the
// ready and hit signals, and the reset values.
module tb_rf_write_arbiter;

`ifdef RF_WRITE_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        mu_valid;
    logic [4:0]  mu_rd;
    logic [31:0] mu_data;
    logic        mu_ready;
    logic [4:0]  chk_rd;
    logic        chk_hit;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_din;

    logic [36:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
        .pipe_stall(pipe_stall),
        .mu_valid(mu_valid), .mu_rd(mu_rd), .mu_data(mu_data), .mu_ready(mu_ready),
        .chk_rd(chk_rd), .chk_hit(chk_hit),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each register-file write must match the next expected write.
    always @(negedge clk) begin
        if (reset && rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got rd=%0d din=%h, expected no write", rf_rd, rf_din);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_rd, rf_din} !== e) begin
                    errors++;
                    $display("FAIL wr_data: got rd=%0d din=%h, expected rd=%0d din=%h",
                             rf_rd, rf_din, e[36:32], e[31:0]);
                end
            end
        end
    end

    // Driver and point-check tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_wb_valid = v;
        pipe_wb_rd    = rd;
        pipe_wb_data  = d;
    endtask

    task automatic set_mu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mu_valid = v;
        mu_rd    = rd;
        mu_data  = d;
    endtask

    initial begin
        reset = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        set_mu(1'b0, 5'd0, 32'h0);
        chk_rd = 5'd0;
        #1;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_rd", {27'd0, rf_rd}, 32'd0);
        check("rst_din", rf_din, 32'd0);
        check("rst_stall", {31'd0, pipe_stall}, 32'd0);
        check("rst_ready", {31'd0, mu_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Pipeline only
        set_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        tick();
        set_pipe(1'b0, 5'd0, 32'h0);
        check("pipe_we", {31'd0, rf_we}, 32'd1);
        check("pipe_stall0", {31'd0, pipe_stall}, 32'd0);
        tick();

        // Write to x0 from the pipeline
        set_pipe(1'b1, 5'd0, 32'h1111_1111);
        tick();
        set_pipe(1'b0, 5'd0, 32'h0);
        check("x0_pipe_we", {31'd0, rf_we}, 32'd0);
        check("x0_pipe_stall", {31'd0, pipe_stall}, 32'd0);

        // Write to x0 from the long-latency unit
        set_mu(1'b1, 5'd0, 32'h2222_2222);
        tick();
        set_mu(1'b0, 5'd0, 32'h0);
        chk_rd = 5'd0;
        #1;
        check("x0_mu_hit", {31'd0, chk_hit}, 32'd0);
        check("x0_mu_we1", {31'd0, rf_we}, 32'd0);
        tick();
        check("x0_mu_we2", {31'd0, rf_we}, 32'd0);
        tick();

        // Latency from an idle arbiter
        set_mu(1'b1, 5'd9, 32'h0000_1234);
        exp_q.push_back({5'd9, 32'h0000_1234});
        tick();
        set_mu(1'b0, 5'd0, 32'h0);
        chk_rd = 5'd9;
        #1;
        check("lat_hit", {31'd0, chk_hit}, BYP ? 32'd0 : 32'd1);
        check("lat_we1", {31'd0, rf_we}, BYP ? 32'd1 : 32'd0);
        tick();
        check("lat_we2", {31'd0, rf_we}, BYP ? 32'd0 : 32'd1);
        tick();

        // Fill the FIFO while the pipeline holds rd=7
        for (int c = 0; c < 4; c++) begin
            set_pipe(1'b1, 5'd7, 32'h0000_0777);
            set_mu(1'b1, 5'(c + 1), 32'hA000_0000 + 32'(c + 1));
            #1;
            check("full_ready_pre", {31'd0, mu_ready}, 32'd1);
            exp_q.push_back({5'd7, 32'h0000_0777});
            tick();
        end
        set_mu(1'b0, 5'd0, 32'h0);
        chk_rd = 5'd3;
        #1;
        check("full_ready", {31'd0, mu_ready}, 32'd0);
        check("full_hit", {31'd0, chk_hit}, 32'd1);

        // Starvation: five further lost cycles, then a forced stall
        for (int c = 4; c < 9; c++) begin
            check("starve_nostall", {31'd0, pipe_stall}, 32'd0);
            exp_q.push_back({5'd7, 32'h0000_0777});
            tick();
        end
        check("starve_stall", {31'd0, pipe_stall}, 32'd1);
        exp_q.push_back({5'd1, 32'hA000_0001});
        tick();
        check("starve_release", {31'd0, pipe_stall}, 32'd0);
        check("starve_ready", {31'd0, mu_ready}, 32'd1);
        check("starve_x1_rd", {27'd0, rf_rd}, 32'd1);
        exp_q.push_back({5'd7, 32'h0000_0777});
        tick();
        check("starve_pipe_rd", {27'd0, rf_rd}, 32'd7);
        set_pipe(1'b0, 5'd0, 32'h0);
        for (int c = 2; c <= 4; c++) begin
            exp_q.push_back({5'(c), 32'hA000_0000 + 32'(c)});
            tick();
        end
        tick();
        check("drain_idle", {31'd0, rf_we}, 32'd0);

        // Reset in the middle of operation, with three entries buffered
        for (int c = 0; c < 3; c++) begin
            set_pipe(1'b1, 5'd7, 32'h0000_0777);
            set_mu(1'b1, 5'(10 + c), 32'hB000_0000 + 32'(c));
            exp_q.push_back({5'd7, 32'h0000_0777});
            tick();
        end
        set_pipe(1'b0, 5'd0, 32'h0);
        set_mu(1'b0, 5'd0, 32'h0);
        chk_rd = 5'd10;
        #1;
        check("mid_hit_pre", {31'd0, chk_hit}, 32'd1);
        #5;
        reset = 1'b0;
        #1;
        check("mid_we", {31'd0, rf_we}, 32'd0);
        check("mid_hit", {31'd0, chk_hit}, 32'd0);
        check("mid_ready", {31'd0, mu_ready}, 32'd1);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_we", {31'd0, rf_we}, 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends on its own.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
